// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//   A multiplexed 7-segment display controller that sits on the MIPS IO bus.
//   Bus writes go to a shadow register set. The shadow set is copied to the
//   active set only at the frame boundary, so digits never show a mix of old
//   and new values. The one exception is CTRL.enable, which acts at once.
//   Each digit is driven for 2^REFRESH_BITS cycles. The top 4 bits of the
//   slot counter are compared with the duty setting to give PWM brightness.
//
//   Optional build macro: SEG7_LZ_SUPPRESS_EN
//   This adds CTRL[1] (lzs), which turns on leading-zero suppression.
//
// Ports
//   CLK          system clock
//   RESET        asynchronous, active-high reset
//   IOWriteEn    bus write strobe, one cycle per write
//   IOAddr       register select: 0 VALUE, 1 MASK, 2 CTRL
//   IOWriteData  write data
//   IOReadData   combinational readback of the shadow set
//   LED          segments gfedcba, registered
//   DP           decimal point, registered
//   AN           digit enables, registered; bit 0 is the LSB digit
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 14,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IOWriteEn,
    input  logic [3:0]            IOAddr,
    input  logic [31:0]           IOWriteData,
    output logic [31:0]           IOReadData,
    output logic [6:0]            LED,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] AN
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [IW-1:0]           LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [REFRESH_BITS-1:0] CNT_MAX  = '1;

    // POL is the electrical level of an inactive (off) output.
    localparam logic                  POL     = (ACTIVE_LOW != 0);
    localparam logic [6:0]            LED_OFF = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

    // Shadow set (bus side).
    logic [VW-1:0]         value_sh_q, value_sh_d;
    logic [NUM_DIGITS-1:0] dpm_sh_q,   dpm_sh_d;
    logic [NUM_DIGITS-1:0] blank_sh_q, blank_sh_d;
    logic [3:0]            duty_sh_q,  duty_sh_d;
    logic                  enable_q,   enable_d;

    // Active set (display side).
    logic [VW-1:0]         value_act_q, value_act_d;
    logic [NUM_DIGITS-1:0] dpm_act_q,   dpm_act_d;
    logic [NUM_DIGITS-1:0] blank_act_q, blank_act_d;
    logic [3:0]            duty_act_q,  duty_act_d;

`ifdef SEG7_LZ_SUPPRESS_EN
    logic lzs_sh_q,  lzs_sh_d;
    logic lzs_act_q, lzs_act_d;
`endif

    // Scan state.
    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;

    // Registered outputs.
    logic [NUM_DIGITS-1:0] an_q,  an_d;
    logic [6:0]            led_q, led_d;
    logic                  dp_q,  dp_d;

    logic       wr_value, wr_mask, wr_ctrl, boundary;
    logic       base_on, seg_on, dp_on;
    logic [3:0] nib_cur;
    logic       unused_wdata;

    logic [3:0]            nib_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz;

    assign unused_wdata = ^IOWriteData;

    // The hex table is stored active-low: 0 means the segment is lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // Split the active value into nibbles.
    // A digit k > 0 is a leading zero when it and every digit above it are 0.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = value_act_q[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign lz[gi] = 1'b0;
            end else begin : g_upper
`ifdef SEG7_LZ_SUPPRESS_EN
                assign lz[gi] = lzs_act_q && (value_act_q[VW-1:4*gi] == '0);
`else
                assign lz[gi] = 1'b0;
`endif
            end
        end
    endgenerate

    always_comb begin
        wr_value = IOWriteEn && (IOAddr == 4'd0);
        wr_mask  = IOWriteEn && (IOAddr == 4'd1);
        wr_ctrl  = IOWriteEn && (IOAddr == 4'd2);

        value_sh_d = wr_value ? IOWriteData[VW-1:0]           : value_sh_q;
        dpm_sh_d   = wr_mask  ? IOWriteData[NUM_DIGITS-1:0]   : dpm_sh_q;
        blank_sh_d = wr_mask  ? IOWriteData[8 +: NUM_DIGITS]  : blank_sh_q;
        duty_sh_d  = wr_ctrl  ? IOWriteData[7:4]              : duty_sh_q;
        enable_d   = wr_ctrl  ? IOWriteData[0]                : enable_q;
`ifdef SEG7_LZ_SUPPRESS_EN
        lzs_sh_d   = wr_ctrl  ? IOWriteData[1]                : lzs_sh_q;
`endif

        // Gate everything with the incoming enable value. This blanks the
        // display and parks the scan on the cycle right after a disabling
        // write.
        boundary = enable_d && (idx_q == LAST_IDX) && (cnt_q == CNT_MAX);

        // The copy uses the registered shadow values. A write that lands on
        // the boundary cycle therefore waits for the next frame.
        value_act_d = boundary ? value_sh_q : value_act_q;
        dpm_act_d   = boundary ? dpm_sh_q   : dpm_act_q;
        blank_act_d = boundary ? blank_sh_q : blank_act_q;
        duty_act_d  = boundary ? duty_sh_q  : duty_act_q;
`ifdef SEG7_LZ_SUPPRESS_EN
        lzs_act_d   = boundary ? lzs_sh_q   : lzs_act_q;
`endif

        if (!enable_d) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
            if (cnt_q == CNT_MAX) begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            end
        end

        // A suppressed digit loses its segments but keeps its DP. The anode
        // stays on when the DP alone is shown.
        nib_cur = nib_arr[idx_q];
        base_on = enable_d && !blank_act_q[idx_q]
                  && (cnt_q[REFRESH_BITS-1 -: 4] <= duty_act_q);
        seg_on  = base_on && !lz[idx_q];
        dp_on   = base_on && dpm_act_q[idx_q];

        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_d[k] = ((seg_on || dp_on) && (idx_q == IW'(k))) ? ~POL : POL;
        end
        if (seg_on) begin
            led_d = POL ? hex_to_seg(nib_cur) : ~hex_to_seg(nib_cur);
        end else begin
            led_d = LED_OFF;
        end
        dp_d = dp_on ? ~POL : POL;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            value_sh_q  <= '0;
            dpm_sh_q    <= '0;
            blank_sh_q  <= '0;
            duty_sh_q   <= 4'hF;
            enable_q    <= 1'b1;
            value_act_q <= '0;
            dpm_act_q   <= '0;
            blank_act_q <= '0;
            duty_act_q  <= 4'hF;
`ifdef SEG7_LZ_SUPPRESS_EN
            lzs_sh_q    <= 1'b0;
            lzs_act_q   <= 1'b0;
`endif
            cnt_q       <= '0;
            idx_q       <= '0;
            an_q        <= AN_OFF;
            led_q       <= LED_OFF;
            dp_q        <= POL;
        end else begin
            value_sh_q  <= value_sh_d;
            dpm_sh_q    <= dpm_sh_d;
            blank_sh_q  <= blank_sh_d;
            duty_sh_q   <= duty_sh_d;
            enable_q    <= enable_d;
            value_act_q <= value_act_d;
            dpm_act_q   <= dpm_act_d;
            blank_act_q <= blank_act_d;
            duty_act_q  <= duty_act_d;
`ifdef SEG7_LZ_SUPPRESS_EN
            lzs_sh_q    <= lzs_sh_d;
            lzs_act_q   <= lzs_act_d;
`endif
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            led_q       <= led_d;
            dp_q        <= dp_d;
        end
    end

    // Readback shows the shadow set. Unused bits read as 0.
    always_comb begin
        IOReadData = '0;
        case (IOAddr)
            4'd0: IOReadData[VW-1:0] = value_sh_q;
            4'd1: begin
                IOReadData[NUM_DIGITS-1:0]  = dpm_sh_q;
                IOReadData[8 +: NUM_DIGITS] = blank_sh_q;
            end
            4'd2: begin
                IOReadData[7:4] = duty_sh_q;
                IOReadData[0]   = enable_q;
`ifdef SEG7_LZ_SUPPRESS_EN
                IOReadData[1]   = lzs_sh_q;
`endif
            end
            default: IOReadData = '0;
        endcase
    end

    assign AN  = an_q;
    assign LED = led_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int RB    = 4;
    localparam int SLOT  = 1 << RB;
    localparam int FRAME = N * SLOT;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IOWriteEn;
    logic [3:0]  IOAddr;
    logic [31:0] IOWriteData;
    logic [31:0] IOReadData;
    logic [6:0]  LED;
    logic        DP;
    logic [3:0]  AN;

    always #5 CLK = ~CLK;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_BITS(RB),
        .ACTIVE_LOW  (1)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOWriteEn  (IOWriteEn),
        .IOAddr     (IOAddr),
        .IOWriteData(IOWriteData),
        .IOReadData (IOReadData),
        .LED        (LED),
        .DP         (DP),
        .AN         (AN)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Segment patterns, active-low, gfedcba.
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: shadow set, active set, and the scan position in
    // cycles since the start of the frame.
    logic [15:0] m_val, a_val;
    logic [3:0]  m_dpm, a_dpm, m_blank, a_blank, m_duty, a_duty;
    logic        m_lzs, a_lzs, m_en;
    int          m_pos;
    logic [3:0]  exp_an;
    logic [6:0]  exp_led;
    logic        exp_dp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:    return {16'h0, m_val};
            4'd1:    return {20'h0, m_blank, 4'h0, m_dpm};
            4'd2:    return {24'h0, m_duty, 2'b00, m_lzs, m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_val = '0; m_dpm = '0; m_blank = '0; m_duty = 4'hF; m_lzs = 1'b0; m_en = 1'b1;
        a_val = '0; a_dpm = '0; a_blank = '0; a_duty = 4'hF; a_lzs = 1'b0;
        m_pos = 0;
        exp_an = 4'hF; exp_led = 7'h7F; exp_dp = 1'b1;
    endtask

    // Apply the effect of one clock edge with the given bus inputs.
    task automatic model_edge(input logic we, input logic [3:0] a, input logic [31:0] d);
        logic new_en, base, lz, seg_on, dp_on;
        int   digit, phase;
        new_en = (we && a == 4'd2) ? d[0] : m_en;
        exp_an = 4'hF; exp_led = 7'h7F; exp_dp = 1'b1;
        if (new_en) begin
            digit  = m_pos / SLOT;
            phase  = (m_pos % SLOT) >> (RB - 4);
            base   = !a_blank[digit] && (phase <= int'(a_duty));
            lz     = a_lzs && (digit > 0) && ((a_val >> (4 * digit)) == 16'h0);
            seg_on = base && !lz;
            dp_on  = base && a_dpm[digit];
            if (seg_on || dp_on) exp_an = 4'hF & ~(4'h1 << digit);
            if (seg_on) exp_led = seg_tab[(a_val >> (4 * digit)) & 16'hF];
            if (dp_on) exp_dp = 1'b0;
        end
        if (new_en && m_pos == FRAME - 1) begin
            a_val = m_val; a_dpm = m_dpm; a_blank = m_blank; a_duty = m_duty; a_lzs = m_lzs;
        end
        m_pos = new_en ? (m_pos + 1) % FRAME : 0;
        if (we) begin
            case (a)
                4'd0: m_val = d[15:0];
                4'd1: begin m_dpm = d[3:0]; m_blank = d[11:8]; end
                4'd2: begin
                    m_duty = d[7:4];
`ifdef SEG7_LZ_SUPPRESS_EN
                    m_lzs = d[1];
`endif
                end
                default: ;
            endcase
        end
        m_en = new_en;
    endtask

    // One clock cycle: drive the bus, check readback, clock, check outputs.
    task automatic step(input logic we, input logic [3:0] a, input logic [31:0] d);
        IOWriteEn = we; IOAddr = a; IOWriteData = d;
        if (we) $display("wr addr=%0d data=0x%08h pos=%0d", a, d, m_pos);
        #1;
        chk($sformatf("rd%0d", a), IOReadData, model_read(a));
        model_edge(we, a, d);
        @(posedge CLK);
        #1;
        chk("AN", {28'h0, AN}, {28'h0, exp_an});
        chk("LED", {25'h0, LED}, {25'h0, exp_led});
        chk("DP", {31'h0, DP}, {31'h0, exp_dp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 3)), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_AN"}, {28'h0, AN}, 32'hF);
        chk({tag, "_LED"}, {25'h0, LED}, 32'h7F);
        chk({tag, "_DP"}, {31'h0, DP}, 32'h1);
    endtask

    initial begin
        RESET = 1'b0; IOWriteEn = 1'b0; IOAddr = 4'd0; IOWriteData = 32'h0;
        #2 RESET = 1'b1;
        #1 check_reset_outputs("rst_async");
        model_reset();
        @(posedge CLK); @(posedge CLK); #1;
        check_reset_outputs("rst_hold");
        #3 RESET = 1'b0;

        // Readback of reset values.
        IOAddr = 4'd0; #1 chk("rst_rd0", IOReadData, 32'h0);
        IOAddr = 4'd2; #1 chk("rst_rd2", IOReadData, 32'h000000F1);

        // Idle scan of zeros.
        idle(FRAME + 8);

        // New value mid-frame; it shows only from the next boundary.
        step(1'b1, 4'd0, 32'h0000A3C5);
        step(1'b0, 4'd0, 32'h0);
        idle(FRAME + 10);

        // Blank digit 1, DPs on digits 0 and 2.
        step(1'b1, 4'd1, 32'h00000205);
        idle(2 * FRAME);

        // Quarter duty, disable, re-enable.
        step(1'b1, 4'd2, 32'h00000031);
        idle(2 * FRAME);
        step(1'b1, 4'd2, 32'h00000030);
        idle(5);
        step(1'b1, 4'd2, 32'h00000031);
        idle(FRAME + 4);
        step(1'b1, 4'd2, 32'h000000F1);

        // Write exactly on the boundary cycle.
        for (int i = 0; i < FRAME + 2 && m_pos != FRAME - 1; i++) step(1'b0, 4'd0, 32'h0);
        chk("bnd_reached", m_pos, FRAME - 1);
        step(1'b1, 4'd0, 32'h00001234);
        idle(2 * FRAME + 2);

        // Unmapped address.
        step(1'b1, 4'd7, 32'hFFFFFFFF);
        step(1'b0, 4'd7, 32'h0);
        idle(FRAME);

`ifdef SEG7_LZ_SUPPRESS_EN
        step(1'b1, 4'd1, 32'h00000000);
        step(1'b1, 4'd0, 32'h00000040);
        step(1'b1, 4'd2, 32'h000000F3);
        idle(2 * FRAME);
        step(1'b1, 4'd0, 32'h00000000);
        idle(2 * FRAME);
        step(1'b1, 4'd1, 32'h00000008);
        idle(2 * FRAME);
`endif

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0]  a;
            logic [31:0] d;
            a = 4'($urandom_range(0, 7));
            d = $urandom;
            if (a == 4'd2) d[0] = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 11) == 0) step(1'b1, a, d);
            else step(1'b0, a, 32'h0);
        end

        // Reset asserted mid-frame between clock edges.
        #2 RESET = 1'b1;
        #1 check_reset_outputs("rst_mid");
        model_reset();
        @(posedge CLK); #1;
        check_reset_outputs("rst_mid_hold");
        IOAddr = 4'd0; #1 chk("rst_mid_rd0", IOReadData, 32'h0);
        #2 RESET = 1'b0;
        idle(FRAME + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
